rr_bus_arbiter: RTL

- Round-robin arbiter sharing one 8-way resource between 8 requesters.
- Issues a one-hot grant plus its 3-bit binary index and a valid flag, in the same form as the team's 8-to-3 one-hot encoder.
- Holds each grant until the owner finishes, drops its request, or exceeds a maximum hold time.
- Sits between the requesting masters and the shared datapath mux, whose select is driven by grant_idx.

---
 rtl/rr_bus_arbiter_pkg.sv | 11 +
 rtl/rr_bus_arbiter_onehot_to_idx8.sv | 18 +
 rtl/rr_bus_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/rr_bus_arbiter_pkg.sv
// Shared types and sizing constants for the round-robin bus arbiter.
package rr_bus_arbiter_pkg;
  localparam int N      = 8;
  localparam int IDX_W  = 3;
  localparam int HOLD_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;
endpackage

// File: rtl/rr_bus_arbiter_onehot_to_idx8.sv
// Combinational 8-bit one-hot to 3-bit index encoder with a valid flag.
module onehot_to_idx8
  import rr_bus_arbiter_pkg::*;
(
  input  logic [N-1:0]     i_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);
  // OR of set-bit positions; exact for one-hot inputs and 0 for all-zero.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (i_onehot[i]) o_idx = o_idx | IDX_W'(i);
    end
  end

  assign o_valid = |i_onehot;
endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter: one registered one-hot grant held until done, request
// drop or hold timeout, with a forced idle cycle between grants.
module rr_bus_arbiter
  import rr_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N-1:0]     i_req,
  input  logic             i_done,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_grant_valid,
  output logic             o_timeout_pulse,
  output state_e           o_state
);
  state_e            r_state, w_nxt_state;
  logic [N-1:0]      r_grant, w_nxt_grant;
  logic [IDX_W-1:0]  r_grant_idx, w_nxt_idx;
  logic [IDX_W-1:0]  r_ptr, w_nxt_ptr, w_sel_idx;
  logic [HOLD_W-1:0] r_hold, w_nxt_hold;
  logic              r_grant_valid, w_nxt_valid;
  logic              r_timeout, w_nxt_timeout;
  logic              w_sel_found, w_release, w_expire;

  // First requester at or above the pointer, wrapping 7 -> 0.
  always_comb begin
    w_sel_idx   = '0;
    w_sel_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_sel_found && i_req[r_ptr + IDX_W'(i)]) begin
        w_sel_idx   = r_ptr + IDX_W'(i);
        w_sel_found = 1'b1;
      end
    end
  end

  assign w_release = i_done | ~i_req[r_grant_idx];
  assign w_expire  = (MAX_HOLD != 0) && (r_hold == HOLD_W'(MAX_HOLD));

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_grant   = r_grant;
    w_nxt_ptr     = r_ptr;
    w_nxt_hold    = r_hold;
    w_nxt_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sel_found) begin
          w_nxt_grant = N'(1) << w_sel_idx;
          w_nxt_hold  = HOLD_W'(1);
          w_nxt_state = BUSY;
        end
      end
      BUSY: begin
        if (w_release || w_expire) begin
          w_nxt_grant   = '0;
          w_nxt_ptr     = r_grant_idx + IDX_W'(1);
          // A coincident done or request drop counts as a normal release.
          w_nxt_timeout = w_expire & ~w_release;
          w_nxt_state   = IDLE;
        end else begin
          w_nxt_hold = r_hold + HOLD_W'(1);
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  onehot_to_idx8 u_enc (
    .i_onehot (w_nxt_grant),
    .o_idx    (w_nxt_idx),
    .o_valid  (w_nxt_valid)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_grant_idx   <= '0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
      r_ptr         <= '0;
      r_hold        <= '0;
    end else begin
      r_state       <= w_nxt_state;
      r_grant       <= w_nxt_grant;
      r_grant_idx   <= w_nxt_idx;
      r_grant_valid <= w_nxt_valid;
      r_timeout     <= w_nxt_timeout;
      r_ptr         <= w_nxt_ptr;
      r_hold        <= w_nxt_hold;
    end
  end

  assign o_grant         = r_grant;
  assign o_grant_idx     = r_grant_idx;
  assign o_grant_valid   = r_grant_valid;
  assign o_timeout_pulse = r_timeout;
  assign o_state         = r_state;
endmodule
